// File: rtl/alu_mdu_if.sv
// Request/result handshake bundle between the execute-stage issuer and alu_mdu.
// master drives requests and accepts results; slave is the ALU/MDU side.
interface alu_mdu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_function;
   logic [XLEN-1:0] in_operand_a;
   logic [XLEN-1:0] in_operand_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_zero;
   logic            out_illegal;

   modport master (
      output in_valid, in_function, in_operand_a, in_operand_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_illegal
   );

   modport slave (
      input  in_valid, in_function, in_operand_a, in_operand_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_illegal
   );
endinterface

// File: rtl/alu_mdu.sv
// Integer ALU plus RV32M multiply/divide on a shared iterative radix-2 datapath.
// Latency: base, illegal and special-case div ops 1 cycle; mul/div XLEN+1 cycles.
// Backpressure: result held while out_ready is low; in_ready drops in MUL/DIV or stalled DONE.
module alu_mdu #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic       clk,
   input  logic       reset,
   alu_mdu_if.slave   bus,
   output logic       busy
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [4:0] F_ADD  = 5'd1,  F_SUB    = 5'd2,  F_SLL   = 5'd3,  F_SRL  = 5'd4;
   localparam logic [4:0] F_SRA  = 5'd5,  F_EQ     = 5'd6,  F_SLT   = 5'd7,  F_SLTU = 5'd8;
   localparam logic [4:0] F_XOR  = 5'd9,  F_OR     = 5'd10, F_AND   = 5'd11, F_MUL  = 5'd12;
   localparam logic [4:0] F_MULH = 5'd13, F_MULHSU = 5'd14, F_MULHU = 5'd15, F_DIV  = 5'd16;
   localparam logic [4:0] F_DIVU = 5'd17, F_REM    = 5'd18, F_REMU  = 5'd19;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUOT, SEL_REM} sel_t;

   state_t state, state_nxt, accept_state;
   sel_t   sel, sel_nxt;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  hi, lo, divisor;
   logic             res_neg, rem_neg;

   logic [XLEN-1:0]    a, b, mag_a, mag_b, quick_res;
   logic [SHAMT_W-1:0] shamt;
   logic               accept, quick, quick_ill, start_mul, sa, sb, b_zero, div_ovf, last_iter;

   assign a      = bus.in_operand_a;
   assign b      = bus.in_operand_b;
   assign shamt  = b[SHAMT_W-1:0];
   assign accept = bus.in_valid && bus.in_ready;
   assign b_zero = (b == '0);
   assign div_ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

   // Decode: anything resolvable without iterating goes straight to DONE.
   always_comb begin
      quick     = 1'b1;
      quick_res = '0;
      quick_ill = 1'b0;
      start_mul = 1'b0;
      sa        = 1'b0;
      sb        = 1'b0;
      sel_nxt   = SEL_LO;
      case (bus.in_function)
         F_ADD:  quick_res = a + b;
         F_SUB:  quick_res = a - b;
         F_SLL:  quick_res = a << shamt;
         F_SRL:  quick_res = a >> shamt;
         F_SRA:  quick_res = $unsigned($signed(a) >>> shamt);
         F_EQ:   quick_res = {{(XLEN-1){1'b0}}, a == b};
         F_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         F_SLTU: quick_res = {{(XLEN-1){1'b0}}, a < b};
         F_XOR:  quick_res = a ^ b;
         F_OR:   quick_res = a | b;
         F_AND:  quick_res = a & b;
         F_MUL, F_MULHU: begin
            quick = 1'b0; start_mul = 1'b1;
            sel_nxt = (bus.in_function == F_MUL) ? SEL_LO : SEL_HI;
         end
         F_MULH: begin
            quick = 1'b0; start_mul = 1'b1; sel_nxt = SEL_HI;
            sa = a[XLEN-1]; sb = b[XLEN-1];
         end
         F_MULHSU: begin
            quick = 1'b0; start_mul = 1'b1; sel_nxt = SEL_HI;
            sa = a[XLEN-1];
         end
         F_DIV, F_REM: begin
            sa = a[XLEN-1]; sb = b[XLEN-1];
            sel_nxt = (bus.in_function == F_DIV) ? SEL_QUOT : SEL_REM;
            if (b_zero)       quick_res = (bus.in_function == F_DIV) ? '1 : a;
            else if (div_ovf) quick_res = (bus.in_function == F_DIV) ? a : '0;
            else              quick = 1'b0;
         end
         F_DIVU, F_REMU: begin
            sel_nxt = (bus.in_function == F_DIVU) ? SEL_QUOT : SEL_REM;
            if (b_zero) quick_res = (bus.in_function == F_DIVU) ? '1 : a;
            else        quick = 1'b0;
         end
         default: quick_ill = 1'b1;
      endcase
   end

   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

   // One radix-2 step: shift-add on {hi,lo} for MUL, restoring subtract for DIV.
   logic [XLEN:0]   mul_sum, div_shift;
   logic [XLEN-1:0] div_diff, hi_step, lo_step;

   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
   assign div_shift = {hi, lo[XLEN-1]};
   assign div_diff  = div_shift[XLEN-1:0] - divisor;

   always_comb begin
      hi_step = hi;
      lo_step = lo;
      if (state == S_MUL) begin
         hi_step = mul_sum[XLEN:1];
         lo_step = {mul_sum[0], lo[XLEN-1:1]};
      end else if (div_shift >= {1'b0, divisor}) begin
         hi_step = div_diff;
         lo_step = {lo[XLEN-2:0], 1'b1};
      end else begin
         hi_step = div_shift[XLEN-1:0];
         lo_step = {lo[XLEN-2:0], 1'b0};
      end
   end

   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quot_s, rem_s, fin_res;

   assign prod   = {hi_step, lo_step};
   assign prod_s = res_neg ? -prod : prod;
   assign quot_s = res_neg ? -lo_step : lo_step;
   assign rem_s  = rem_neg ? -hi_step : hi_step;

   always_comb begin
      case (sel)
         SEL_LO:   fin_res = prod_s[XLEN-1:0];
         SEL_HI:   fin_res = prod_s[2*XLEN-1:XLEN];
         SEL_QUOT: fin_res = quot_s;
         default:  fin_res = rem_s;
      endcase
   end

   assign last_iter = busy && (cnt == CNT_W'(XLEN-1));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      accept_state = quick ? S_DONE : (start_mul ? S_MUL : S_DIV);
      state_nxt    = state;
      case (state)
         S_IDLE:       if (accept) state_nxt = accept_state;
         S_MUL, S_DIV: if (last_iter) state_nxt = S_DONE;
         default: begin
            if (bus.out_ready) state_nxt = accept ? accept_state : S_IDLE;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
      bus.out_valid = (state == S_DONE);
      busy          = (state == S_MUL) || (state == S_DIV);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt             <= '0;
         hi              <= '0;
         lo              <= '0;
         divisor         <= '0;
         res_neg         <= 1'b0;
         rem_neg         <= 1'b0;
         sel             <= SEL_LO;
         bus.out_result  <= '0;
         bus.out_zero    <= 1'b0;
         bus.out_illegal <= 1'b0;
      end else if (accept) begin
         if (quick) begin
            bus.out_result  <= quick_res;
            bus.out_zero    <= (quick_res == '0);
            bus.out_illegal <= quick_ill;
         end else begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= mag_a;
            divisor <= mag_b;
            res_neg <= sa ^ sb;
            rem_neg <= sa;
            sel     <= sel_nxt;
         end
      end else if (busy) begin
         hi  <= hi_step;
         lo  <= lo_step;
         cnt <= cnt + CNT_W'(1);
         if (last_iter) begin
            bus.out_result  <= fin_res;
            bus.out_zero    <= (fin_res == '0);
            bus.out_illegal <= 1'b0;
         end
      end
   end
endmodule
